// File: rtl/interval_timer_ctrl_pkg.sv
// Shared definitions for the interval timer: state encoding and default widths.
package interval_timer_ctrl_pkg;

   localparam int unsigned DEF_N   = 8;
   localparam int unsigned DEF_DIV = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10
   } state_e;

endpackage

// File: rtl/interval_timer_ctrl_if.sv
// Control/status bundle between a timer user (master) and interval_timer_ctrl (slave).
interface interval_timer_ctrl_if
   import interval_timer_ctrl_pkg::*;
#(
   parameter int unsigned N = DEF_N
);
   logic         start;
   logic         stop;
   logic         hold;
   logic         oneshot;
   logic [N-1:0] period;
   logic [N-1:0] q;
   logic         busy;
   logic         done_tick;

   modport master (output start, stop, hold, oneshot, period,
                   input  q, busy, done_tick);
   modport slave  (input  start, stop, hold, oneshot, period,
                   output q, busy, done_tick);
endinterface

// File: rtl/interval_timer_ctrl_mod_counter_en.sv
// W-bit counter with synchronous clear and enable; wraps to 0 after reaching max_val.
module mod_counter_en #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] max_val,
   output logic [W-1:0] q,
   output logic         max_tick
);

   assign max_tick = (q == max_val);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         q <= '0;
      else if (clr)
         q <= '0;
      else if (en)
         q <= max_tick ? '0 : q + W'(1);
   end

endmodule

// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer sequencer (start/stop/hold, one-shot or periodic).
// Optional divide-by-DIV prescaler on every advance: define TIMER_PRESCALE_EN.
module interval_timer_ctrl
   import interval_timer_ctrl_pkg::*;
#(
   parameter int unsigned N   = DEF_N,
   parameter int unsigned DIV = DEF_DIV
) (
   input  logic                 clk,
   input  logic                 reset,
   interval_timer_ctrl_if.slave bus
);

   if (DIV < 2 || DIV > 65536) begin : g_div_check
      $error("interval_timer_ctrl: DIV must be in 2..65536");
   end

   state_e       state, state_nxt;
   logic [N-1:0] period_reg;
   logic         mode_reg;
   logic         active;
   logic         pre_tick;
   logic         advance;
   logic         cnt_max;
   logic         expire;

   assign active = (state != ST_IDLE);

   // stop/start override any advance, so a coincident expiry is never reported
   assign advance = active & ~bus.hold & ~bus.start & ~bus.stop & pre_tick;
   assign expire  = advance & cnt_max;

`ifdef TIMER_PRESCALE_EN
   localparam int unsigned PW = $clog2(DIV);
   logic [PW-1:0] pre_q;
   logic          pre_max;

   mod_counter_en #(.W(PW)) u_prescale (
      .clk      (clk),
      .reset    (reset),
      .clr      (bus.start | bus.stop),
      .en       (active & ~bus.hold),
      .max_val  (PW'(DIV - 1)),
      .q        (pre_q),
      .max_tick (pre_max)
   );
   assign pre_tick = pre_max;
`else
   assign pre_tick = 1'b1;
`endif

   mod_counter_en #(.W(N)) u_count (
      .clk      (clk),
      .reset    (reset),
      .clr      (bus.start | bus.stop),
      .en       (advance),
      .max_val  (period_reg),
      .q        (bus.q),
      .max_tick (cnt_max)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Priority: stop > start > terminal count > hold
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  state_nxt = ST_IDLE;
         ST_RUN,
         ST_PAUSE: begin
            if (expire && mode_reg)
               state_nxt = ST_IDLE;
            else
               state_nxt = bus.hold ? ST_PAUSE : ST_RUN;
         end
         default:  state_nxt = ST_IDLE;
      endcase
      if (bus.start)
         state_nxt = ST_RUN;
      if (bus.stop)
         state_nxt = ST_IDLE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         period_reg    <= '0;
         mode_reg      <= 1'b0;
         bus.busy      <= 1'b0;
         bus.done_tick <= 1'b0;
      end else begin
         bus.busy      <= (state_nxt != ST_IDLE);
         bus.done_tick <= expire;
         if (bus.start) begin
            period_reg <= bus.period;
            mode_reg   <= bus.oneshot;
         end
      end
   end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Self-checking bench for interval_timer_ctrl: directed scenarios plus randomized model compare.
module tb_interval_timer_ctrl;

   localparam int unsigned N   = 8;
   localparam int unsigned DIV = 4;

   logic clk = 1'b0;
   logic reset;

   interval_timer_ctrl_if #(.N(N)) bus ();

   interval_timer_ctrl #(.N(N), .DIV(DIV)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Behavioural model: active flag, count, latched interval and mode
   int m_q, m_per;
   bit m_act, m_os, m_done;
`ifdef TIMER_PRESCALE_EN
   int m_pre;
`endif

   task automatic model_reset();
      m_q = 0; m_per = 0; m_act = 0; m_os = 0; m_done = 0;
`ifdef TIMER_PRESCALE_EN
      m_pre = 0;
`endif
   endtask

   // Drive one cycle of inputs, advance the model across the edge, settle 1 time unit.
   task automatic cyc(input bit s, input bit p, input bit h, input bit o, input int per);
      bit tick;
      bus.start = s; bus.stop = p; bus.hold = h; bus.oneshot = o; bus.period = N'(per);
      @(posedge clk);
      m_done = 0;
      if (p) begin
         m_act = 0; m_q = 0;
`ifdef TIMER_PRESCALE_EN
         m_pre = 0;
`endif
      end else if (s) begin
         m_act = 1; m_q = 0; m_per = per % (2**N); m_os = o;
`ifdef TIMER_PRESCALE_EN
         m_pre = 0;
`endif
      end else if (m_act && !h) begin
         tick = 1;
`ifdef TIMER_PRESCALE_EN
         if (m_pre == DIV - 1) m_pre = 0;
         else begin m_pre++; tick = 0; end
`endif
         if (tick) begin
            if (m_q == m_per) begin
               m_q = 0; m_done = 1;
               if (m_os) m_act = 0;
            end else begin
               m_q = (m_q + 1) % (2**N);
            end
         end
      end
      #1;
   endtask

   task automatic idle_cyc();
      cyc(0, 0, 0, 1'($urandom), int'($urandom_range(0, 255)));
   endtask

   task automatic test_reset();
      checks++;
      if ({bus.q, bus.busy, bus.done_tick} !== {N'(0), 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_asserted: q=%0d busy=%b done=%b, want 0 0 0", bus.q, bus.busy, bus.done_tick);
      end
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         idle_cyc();
         checks++;
         if ({bus.q, bus.busy, bus.done_tick} !== {N'(0), 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_idle[%0d]: q=%0d busy=%b done=%b, want 0 0 0", i, bus.q, bus.busy, bus.done_tick);
         end
      end
   endtask

   task automatic test_oneshot();
      int eq; bit eb, ed;
      cyc(1, 0, 0, 1, 5);
      for (int t = 0; t <= 8; t++) begin
         if (t > 0) idle_cyc();
         eq = (t <= 5) ? t : 0; eb = (t <= 5); ed = (t == 6);
         checks++;
         if ({bus.q, bus.busy, bus.done_tick} !== {N'(eq), eb, ed}) begin
            errors++;
            $display("FAIL oneshot[t=%0d]: q=%0d busy=%b done=%b, want q=%0d busy=%b done=%b",
                     t, bus.q, bus.busy, bus.done_tick, eq, eb, ed);
         end
      end
   endtask

   task automatic test_periodic();
      cyc(1, 0, 0, 0, 3);
      for (int t = 1; t <= 40; t++) begin
         cyc(0, 0, 0, 1'($urandom), 7);
         checks++;
         if ({bus.q, bus.busy, bus.done_tick} !== {N'(t % 4), 1'b1, (t % 4 == 0)}) begin
            errors++;
            $display("FAIL periodic[t=%0d]: q=%0d busy=%b done=%b, want q=%0d busy=1 done=%b",
                     t, bus.q, bus.busy, bus.done_tick, t % 4, (t % 4 == 0));
         end
      end
      cyc(0, 1, 0, 0, 0);
   endtask

   task automatic test_hold();
      int eq;
      cyc(1, 0, 0, 0, 9);
      for (int t = 1; t <= 14; t++) begin
         cyc(0, 0, (t >= 5 && t <= 7), 0, 0);
         eq = (t <= 4) ? t : (t <= 7) ? 4 : (t <= 12) ? t - 3 : (t == 13) ? 0 : 1;
         checks++;
         if ({bus.q, bus.busy, bus.done_tick} !== {N'(eq), 1'b1, (t == 13)}) begin
            errors++;
            $display("FAIL hold[t=%0d]: q=%0d busy=%b done=%b, want q=%0d busy=1 done=%b",
                     t, bus.q, bus.busy, bus.done_tick, eq, (t == 13));
         end
      end
      // hold together with start: enter RUN, then pause while hold stays high
      cyc(1, 0, 1, 0, 2);
      for (int t = 1; t <= 4; t++) begin
         cyc(0, 0, (t <= 2), 0, 0);
         eq = (t <= 2) ? 0 : t - 2;
         checks++;
         if ({bus.q, bus.busy} !== {N'(eq), 1'b1}) begin
            errors++;
            $display("FAIL start_hold[t=%0d]: q=%0d busy=%b, want q=%0d busy=1", t, bus.q, bus.busy, eq);
         end
      end
      cyc(0, 1, 0, 0, 0);
   endtask

   task automatic test_stop();
      cyc(1, 0, 0, 0, 6);
      for (int t = 1; t <= 6; t++) idle_cyc();
      checks++;
      if (bus.q !== N'(6)) begin
         errors++;
         $display("FAIL stop_pre: q=%0d, want 6", bus.q);
      end
      cyc(0, 1, 0, 0, 0);
      for (int t = 0; t < 4; t++) begin
         if (t == 2) cyc(1, 1, 0, 0, 3);
         else if (t > 0) idle_cyc();
         checks++;
         if ({bus.q, bus.busy, bus.done_tick} !== {N'(0), 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL stop[t=%0d]: q=%0d busy=%b done=%b, want 0 0 0", t, bus.q, bus.busy, bus.done_tick);
         end
      end
   endtask

   task automatic test_restart();
      cyc(1, 0, 0, 0, 7);
      idle_cyc();
      idle_cyc();
      cyc(1, 0, 0, 0, 1);
      for (int t = 0; t <= 6; t++) begin
         if (t > 0) cyc(0, 0, 0, 1'($urandom), 200);
         checks++;
         if ({bus.q, bus.busy, bus.done_tick} !== {N'(t % 2), 1'b1, (t > 0 && t % 2 == 0)}) begin
            errors++;
            $display("FAIL restart[t=%0d]: q=%0d busy=%b done=%b, want q=%0d busy=1 done=%b",
                     t, bus.q, bus.busy, bus.done_tick, t % 2, (t > 0 && t % 2 == 0));
         end
      end
      cyc(0, 1, 0, 0, 0);
   endtask

   task automatic test_wrap();
      cyc(1, 0, 0, 0, 255);
      for (int t = 1; t <= 257; t++) begin
         cyc(0, 0, 0, 0, 0);
         if (t >= 254) begin
            checks++;
            if ({bus.q, bus.busy, bus.done_tick} !== {N'(t % 256), 1'b1, (t == 256)}) begin
               errors++;
               $display("FAIL wrap[t=%0d]: q=%0d busy=%b done=%b, want q=%0d busy=1 done=%b",
                        t, bus.q, bus.busy, bus.done_tick, t % 256, (t == 256));
            end
         end
      end
      cyc(0, 1, 0, 0, 0);
   endtask

   task automatic test_async_reset();
      cyc(1, 0, 0, 0, 3);
      for (int t = 1; t <= 4; t++) idle_cyc();
      checks++;
      if (bus.done_tick !== 1'b1) begin
         errors++;
         $display("FAIL areset_pre: done=%b, want 1", bus.done_tick);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({bus.q, bus.busy, bus.done_tick} !== {N'(0), 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL areset: q=%0d busy=%b done=%b, want 0 0 0", bus.q, bus.busy, bus.done_tick);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      idle_cyc();
      checks++;
      if ({bus.q, bus.busy, bus.done_tick} !== {N'(0), 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL areset_after: q=%0d busy=%b done=%b, want 0 0 0", bus.q, bus.busy, bus.done_tick);
      end
   endtask

`ifdef TIMER_PRESCALE_EN
   task automatic test_prescale();
      cyc(1, 0, 0, 0, 2);
      for (int t = 1; t <= 12; t++) begin
         idle_cyc();
         checks++;
         if ({bus.q, bus.done_tick} !== {N'((t / DIV) % 3), (t == 12)}) begin
            errors++;
            $display("FAIL prescale[t=%0d]: q=%0d done=%b, want q=%0d done=%b",
                     t, bus.q, bus.done_tick, (t / DIV) % 3, (t == 12));
         end
      end
      cyc(0, 1, 0, 0, 0);
   endtask
`endif

   task automatic test_random();
      bit s, p, h;
      for (int i = 0; i < 3000; i++) begin
         s = ($urandom % 16 == 0);
         p = ($urandom % 40 == 0);
         h = ($urandom % 5 == 0);
         cyc(s, p, h, 1'($urandom), int'($urandom_range(0, 12)));
         checks++;
         if ({bus.q, bus.busy, bus.done_tick} !== {N'(m_q), m_act, m_done}) begin
            errors++;
            $display("FAIL random[%0d]: q=%0d busy=%b done=%b, want q=%0d busy=%b done=%b",
                     i, bus.q, bus.busy, bus.done_tick, m_q, m_act, m_done);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      bus.start = 0; bus.stop = 0; bus.hold = 0; bus.oneshot = 0; bus.period = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      test_reset();
`ifdef TIMER_PRESCALE_EN
      test_prescale();
`else
      test_oneshot();
      test_periodic();
      test_hold();
      test_stop();
      test_restart();
      test_wrap();
`endif
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
